fclass_wb: RTL

- Writeback buffer directly downstream of the FP classify stage.
- Captures each 32-bit class mask that classify produces, with its destination-register tag, and queues it in a small FIFO for the integer writeback port.
- Checks that every mask is well-formed and keeps a saturating count of NaN classifications for debug.
- Decouples the combinational classify path from integer-port backpressure using a valid/ready handshake on both sides.

---
 rtl/fpu_pkg.sv | 32 +++
 rtl/fpu_sync_fifo.sv | 68 ++++++
 rtl/fclass_wb.sv | 90 +++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FP classify definitions: class-mask bit positions, mask type and
// a well-formedness helper used by the classify writeback buffer.
package fpu_pkg;

  // Number of meaningful class bits at the bottom of the 32-bit mask
  localparam int CLS_W = 10;

  // Class bit positions within the mask
  localparam int CLS_NINF  = 0;
  localparam int CLS_NNORM = 1;
  localparam int CLS_NSUB  = 2;
  localparam int CLS_NZERO = 3;
  localparam int CLS_PZERO = 4;
  localparam int CLS_PSUB  = 5;
  localparam int CLS_PNORM = 6;
  localparam int CLS_PINF  = 7;
  localparam int CLS_SNAN  = 8;
  localparam int CLS_QNAN  = 9;

  typedef logic [CLS_W-1:0] cls_mask_t;

  // A valid classification sets exactly one class bit
  function automatic logic cls_onehot(input cls_mask_t m);
    logic [3:0] ones;
    ones = '0;
    for (int i = 0; i < CLS_W; i++) begin
      ones = ones + {3'b000, m[i]};
    end
    return (ones == 4'd1);
  endfunction

endpackage

// File: rtl/fpu_sync_fifo.sv
// Generic synchronous circular-buffer FIFO with flush. Outputs read the head
// entry directly so a pushed entry is visible the cycle after the push; the
// head reads as zero whenever the FIFO is empty.
module fpu_sync_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_reg == DEPTH_C);
  assign empty = (count_reg == '0);

  // Flush kills both sides; a full FIFO never accepts, an empty one never pops
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Storage write; contents need no reset because the head is gated by empty
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_data = empty ? '0 : mem[rd_ptr_reg];
  assign count   = count_reg;

endmodule

// File: rtl/fclass_wb.sv
// Writeback buffer behind the FP classify stage: queues {tag, class[9:0]}
// for the integer writeback port, flags malformed masks (sticky) and keeps a
// saturating count of NaN classifications for debug.
module fclass_wb
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_class,
  input  logic [TAG_W-1:0]       in_tag,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_data,
  output logic [TAG_W-1:0]       out_tag,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err_malformed,
  output logic [CNT_W-1:0]       nan_count
);

  localparam int EW = CLS_W + TAG_W;

  logic             fifo_full;
  logic             fifo_empty;
  logic [EW-1:0]    head;
  logic             push;
  logic             pop;
  cls_mask_t        cls;
  logic             malformed;
  logic             is_nan;
  logic             err_malformed_reg;
  logic [CNT_W-1:0] nan_count_reg;

  // Acceptance never depends on out_ready, so a full buffer cannot pass through
  assign in_ready  = !fifo_full && !flush;
  assign push      = in_valid && in_ready;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  assign cls       = in_class[CLS_W-1:0];
  assign malformed = !cls_onehot(cls) || (|in_class[31:CLS_W]);
  assign is_nan    = cls[CLS_SNAN] || cls[CLS_QNAN];

  fpu_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data ({in_tag, cls}),
    .rd_data (head),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Sticky malformed-mask flag; the entry itself is still queued
  always_ff @(posedge clk) begin
    if (rst) begin
      err_malformed_reg <= 1'b0;
    end else if (push && malformed) begin
      err_malformed_reg <= 1'b1;
    end
  end

  // Saturating NaN counter; survives flush, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      nan_count_reg <= '0;
    end else if (push && is_nan && (nan_count_reg != {CNT_W{1'b1}})) begin
      nan_count_reg <= nan_count_reg + 1'b1;
    end
  end

  // Head fields read as zero when empty because the FIFO gates its read data
  assign out_data      = {{(32-CLS_W){1'b0}}, head[CLS_W-1:0]};
  assign out_tag       = head[CLS_W +: TAG_W];
  assign err_malformed = err_malformed_reg;
  assign nan_count     = nan_count_reg;

endmodule
